// File: rtl/console_uart.sv
// Console serial port: 8N1 transmitter with a one-byte holding register and
// a 16x-oversampling receiver that reports overrun and framing errors.
module console_uart #(
   parameter int CLKS_PER_TICK = 27
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_ready,
   output logic       rs232_tx,
   input  logic       rs232_rx,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   input  logic       rx_rd,
   output logic       rx_overrun,
   output logic       rx_framing_err
);

   // state | meaning (both FSMs)
   // IDLE  | line idle, waiting for work / a start edge
   // START | start bit (TX: 16 ticks, RX: 8 ticks to mid-bit)
   // DATA  | 8 data bits, LSB first, 16 ticks each
   // STOP  | stop bit, 16 ticks
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam int TCW = $clog2(CLKS_PER_TICK);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(CLKS_PER_TICK - 1);

   logic [TCW-1:0] r_tick_cnt;
   logic           r_tick;

   tx_state_t      r_tx_state;
   logic [3:0]     r_tx_tcnt;
   logic [2:0]     r_tx_bit;
   logic [7:0]     r_tx_shift;
   logic [7:0]     r_tx_hold;
   logic           r_tx_ready;
   logic           r_tx;

   logic           r_rx_s1;
   logic           r_rx_s2;
   rx_state_t      r_rx_state;
   logic [3:0]     r_rx_tcnt;
   logic [2:0]     r_rx_bit;
   logic [7:0]     r_rx_shift;
   logic [7:0]     r_rx_data;
   logic           r_rx_ready;
   logic           r_rx_overrun;
   logic           r_rx_ferr;
   logic           w_rd;

   assign w_rd = rx_rd && r_rx_ready;

   // tick is registered so it is high during the cycle the counter reads 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (r_tick_cnt == TICK_LAST) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b1;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
         r_tick     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_tcnt  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_hold  <= '0;
         r_tx_ready <= 1'b1;
         r_tx       <= 1'b1;
      end else begin
         if (tx_wr && r_tx_ready) begin
            r_tx_hold  <= tx_data;
            r_tx_ready <= 1'b0;
         end
         if (r_tick) begin
            case (r_tx_state)
               TX_IDLE: begin
                  if (!r_tx_ready) begin
                     r_tx_shift <= r_tx_hold;
                     r_tx_ready <= 1'b1;
                     r_tx       <= 1'b0;
                     r_tx_tcnt  <= '0;
                     r_tx_state <= TX_START;
                  end
               end
               TX_START: begin
                  r_tx_tcnt <= r_tx_tcnt + 4'd1;
                  if (r_tx_tcnt == 4'd15) begin
                     r_tx       <= r_tx_shift[0];
                     r_tx_bit   <= '0;
                     r_tx_state <= TX_DATA;
                  end
               end
               TX_DATA: begin
                  r_tx_tcnt <= r_tx_tcnt + 4'd1;
                  if (r_tx_tcnt == 4'd15) begin
                     if (r_tx_bit == 3'd7) begin
                        r_tx       <= 1'b1;
                        r_tx_state <= TX_STOP;
                     end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx       <= r_tx_shift[1];
                     end
                  end
               end
               TX_STOP: begin
                  r_tx_tcnt <= r_tx_tcnt + 4'd1;
                  if (r_tx_tcnt == 4'd15) begin
                     // a queued byte follows with no idle gap
                     if (!r_tx_ready) begin
                        r_tx_shift <= r_tx_hold;
                        r_tx_ready <= 1'b1;
                        r_tx       <= 1'b0;
                        r_tx_state <= TX_START;
                     end else begin
                        r_tx_state <= TX_IDLE;
                     end
                  end
               end
               default: r_tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // synchronizer resets to the idle level so reset release is not a start edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= rs232_rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_state   <= RX_IDLE;
         r_rx_tcnt    <= '0;
         r_rx_bit     <= '0;
         r_rx_shift   <= '0;
         r_rx_data    <= '0;
         r_rx_ready   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_rx_ferr    <= 1'b0;
      end else begin
         if (w_rd) begin
            r_rx_ready   <= 1'b0;
            r_rx_overrun <= 1'b0;
         end
         if (r_tick) begin
            case (r_rx_state)
               RX_IDLE: begin
                  if (!r_rx_s2) begin
                     r_rx_tcnt  <= '0;
                     r_rx_state <= RX_START;
                  end
               end
               RX_START: begin
                  r_rx_tcnt <= r_rx_tcnt + 4'd1;
                  if (r_rx_tcnt == 4'd7) begin
                     r_rx_tcnt  <= '0;
                     r_rx_bit   <= '0;
                     r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                  end
               end
               RX_DATA: begin
                  r_rx_tcnt <= r_rx_tcnt + 4'd1;
                  if (r_rx_tcnt == 4'd15) begin
                     r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                     r_rx_bit   <= r_rx_bit + 3'd1;
                     if (r_rx_bit == 3'd7)
                        r_rx_state <= RX_STOP;
                  end
               end
               RX_STOP: begin
                  r_rx_tcnt <= r_rx_tcnt + 4'd1;
                  if (r_rx_tcnt == 4'd15) begin
                     r_rx_data  <= r_rx_shift;
                     r_rx_ferr  <= ~r_rx_s2;
                     r_rx_ready <= 1'b1;
                     // a read landing on the completion cycle consumed the old byte
                     if (r_rx_ready)
                        r_rx_overrun <= ~rx_rd;
                     r_rx_state <= RX_IDLE;
                  end
               end
               default: r_rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   assign tx_ready       = r_tx_ready;
   assign rs232_tx       = r_tx;
   assign rx_data        = r_rx_data;
   assign rx_ready       = r_rx_ready;
   assign rx_overrun     = r_rx_overrun;
   assign rx_framing_err = r_rx_ferr;

endmodule

// File: tb/tb_console_uart.sv
// Directed bench for console_uart with CLKS_PER_TICK=4 (one bit = 64 clocks).
module tb_console_uart;

   localparam int CPT = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_wr = 1'b0;
   logic       rx_rd = 1'b0;
   logic       drv_rx = 1'b1;
   logic       loop_en = 1'b0;
   logic       tx_ready, rs232_tx, rx_ready, rx_overrun, rx_framing_err;
   logic [7:0] rx_data;
   logic       rx_line;

   int tests = 0;
   int fails = 0;
   int k, kk;
   logic saw_low;

   assign rx_line = loop_en ? rs232_tx : drv_rx;

   console_uart #(.CLKS_PER_TICK(CPT)) dut (
      .clk(clk), .reset_n(reset_n),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready), .rs232_tx(rs232_tx),
      .rs232_rx(rx_line), .rx_data(rx_data), .rx_ready(rx_ready), .rx_rd(rx_rd),
      .rx_overrun(rx_overrun), .rx_framing_err(rx_framing_err)
   );

   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [7:0] b);
      tx_data = b;
      tx_wr = 1'b1;
      @(negedge clk);
      tx_wr = 1'b0;
   endtask

   task automatic rd_pulse();
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   // start bit must appear within CLKS_PER_TICK+1 clocks of the write
   task automatic wait_tx_start(input string tag);
      int n;
      n = 0;
      while (rs232_tx !== 1'b0 && n < CPT + 2) begin
         @(negedge clk);
         n++;
      end
      check1(tag, rs232_tx, 1'b0);
   endtask

   task automatic wait_rx_ready(input string tag, input int lim);
      int n;
      n = 0;
      while (rx_ready !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      check1(tag, rx_ready, 1'b1);
   endtask

   // called on the negedge where the start bit is first seen
   task automatic check_bits(input logic [7:0] b, input string tag);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int j = 0; j < 640; j++) begin
         if (j % 64 == 1 || j % 64 == 63)
            check1($sformatf("%s_bit%0d_off%0d", tag, j / 64, j % 64), rs232_tx, fr[j / 64]);
         @(negedge clk);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drv_rx = fr[i];
         repeat (64) @(negedge clk);
      end
      drv_rx = 1'b1;
   endtask

   task automatic watch_tx_quiet(input int n);
      saw_low = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (rs232_tx !== 1'b1) saw_low = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clks(2);
      check1("rst_tx", rs232_tx, 1'b1);
      check1("rst_tx_ready", tx_ready, 1'b1);
      check1("rst_rx_ready", rx_ready, 1'b0);
      check8("rst_rx_data", rx_data, 8'h00);
      check1("rst_overrun", rx_overrun, 1'b0);
      check1("rst_ferr", rx_framing_err, 1'b0);
      reset_n = 1'b1;
      clks(3);

      // reset in the middle of an A5 frame with a second byte queued
      tx_write(8'hA5);
      wait_tx_start("a5_start");
      clks(140);
      check1("a5_bit1_low", rs232_tx, 1'b0);
      tx_write(8'h3C);
      check1("hold_full", tx_ready, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      check1("abort_tx", rs232_tx, 1'b1);
      check1("abort_tx_ready", tx_ready, 1'b1);
      check1("abort_rx_ready", rx_ready, 1'b0);
      check8("abort_rx_data", rx_data, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      watch_tx_quiet(300);
      check1("no_tx_after_reset", saw_low, 1'b0);

      // single frame
      tx_write(8'h55);
      check1("tx_ready_fall", tx_ready, 1'b0);
      wait_tx_start("55_start");
      check1("tx_ready_reload", tx_ready, 1'b1);
      check_bits(8'h55, "f55");
      check1("55_idle", rs232_tx, 1'b1);

      // back-to-back frames, third write ignored
      clks(10);
      tx_write(8'h41);
      wait_tx_start("41_start");
      check1("41_ready", tx_ready, 1'b1);
      fork
         begin
            check_bits(8'h41, "fA");
            check_bits(8'h42, "fB");
         end
         begin
            tx_data = 8'h42;
            tx_wr = 1'b1;
            @(negedge clk);
            tx_wr = 1'b0;
            check1("b_queued", tx_ready, 1'b0);
            tx_data = 8'hFF;
            tx_wr = 1'b1;
            @(negedge clk);
            tx_wr = 1'b0;
            check1("ff_while_full", tx_ready, 1'b0);
         end
      join
      check1("b2b_idle", rs232_tx, 1'b1);
      watch_tx_quiet(300);
      check1("ff_not_sent", saw_low, 1'b0);
      check1("b2b_tx_ready", tx_ready, 1'b1);

      // loopback
      loop_en = 1'b1;
      tx_write(8'hC3);
      wait_rx_ready("c3_ready", 1000);
      check8("c3_data", rx_data, 8'hC3);
      check1("c3_ferr", rx_framing_err, 1'b0);
      check1("c3_overrun", rx_overrun, 1'b0);
      rd_pulse();
      check1("c3_read_clears", rx_ready, 1'b0);
      clks(100);
      loop_en = 1'b0;
      rd_pulse();
      check1("idle_read_ready", rx_ready, 1'b0);
      check8("idle_read_data", rx_data, 8'hC3);
      check1("idle_read_overrun", rx_overrun, 1'b0);

      // overrun
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      clks(4);
      check1("ovr_ready", rx_ready, 1'b1);
      check1("ovr_flag", rx_overrun, 1'b1);
      check8("ovr_data", rx_data, 8'h22);
      rd_pulse();
      check1("ovr_read_ready", rx_ready, 1'b0);
      check1("ovr_read_flag", rx_overrun, 1'b0);

      // read on the completion cycle of the second byte
      clks(8);
      fork
         begin
            send_rx(8'h11, 1'b1);
            send_rx(8'h22, 1'b1);
         end
         begin
            k = 0;
            while (rx_ready !== 1'b1 && k < 700) begin
               @(negedge clk);
               k++;
            end
            check1("sim_first_ready", rx_ready, 1'b1);
            check8("sim_first_data", rx_data, 8'h11);
            check1("rx_latency", (k >= 611 && k <= 614), 1'b1);
            kk = k;
            while (k < 640 + kk - 1) begin
               @(negedge clk);
               k++;
            end
            check1("sim_pre_ready", rx_ready, 1'b1);
            rd_pulse();
            check1("sim_ready", rx_ready, 1'b1);
            check1("sim_overrun", rx_overrun, 1'b0);
            check8("sim_data", rx_data, 8'h22);
         end
      join
      rd_pulse();
      check1("sim_read_clears", rx_ready, 1'b0);

      // glitch shorter than half a bit
      clks(10);
      drv_rx = 1'b0;
      clks(20);
      drv_rx = 1'b1;
      clks(700);
      check1("glitch_ready", rx_ready, 1'b0);
      check1("glitch_overrun", rx_overrun, 1'b0);
      check1("glitch_ferr", rx_framing_err, 1'b0);
      check8("glitch_data", rx_data, 8'h22);

      // framing error still delivers the byte
      send_rx(8'h7E, 1'b0);
      clks(100);
      check1("fe_ready", rx_ready, 1'b1);
      check8("fe_data", rx_data, 8'h7E);
      check1("fe_flag", rx_framing_err, 1'b1);
      check1("fe_overrun", rx_overrun, 1'b0);

      // a good frame clears the framing flag
      rd_pulse();
      send_rx(8'h5A, 1'b1);
      clks(4);
      check1("ok_ready", rx_ready, 1'b1);
      check8("ok_data", rx_data, 8'h5A);
      check1("ok_ferr", rx_framing_err, 1'b0);
      check1("ok_overrun", rx_overrun, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
